ps2_keyboard: RTL and testbench

- Upstream producer of the `input_ascii` / `input_en` keyboard MMIO pair consumed by the SoC top.
- Receives PS/2 device frames and decodes set-2 scancodes, including break and extended prefixes.
- Translates make codes to ASCII and queues characters in a first-word-fall-through (FWFT) FIFO.
- The CPU pops one character per read of the key MMIO address. Runs on CLOCK_50.

---
 rtl/ps2_keyboard_pkg.sv | 20 ++
 rtl/ps2_keyboard_scancode_to_ascii.sv | 43 ++++
 rtl/ps2_keyboard.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ps2_keyboard_pkg.sv
// Shared constants and decoder state encodings for the PS/2 keyboard front end.
// Optional shift-key support is enabled by defining KB_SHIFT_EN at build time
// (left undefined by default).
package ps2_keyboard_pkg;

    localparam logic [7:0] KB_BRK    = 8'hF0;
    localparam logic [7:0] KB_EXT    = 8'hE0;
    localparam logic [7:0] KB_LSHIFT = 8'h12;
    localparam logic [7:0] KB_RSHIFT = 8'h59;

    localparam int unsigned FRAME_LAST_BIT = 10;

    typedef enum logic [1:0] {
        S_NORM   = 2'd0,
        S_BRK    = 2'd1,
        S_EXT    = 2'd2,
        S_EXTBRK = 2'd3
    } kb_state_e;

endpackage

// File: rtl/ps2_keyboard_scancode_to_ascii.sv
// Combinational set-2 make code to ASCII translation; unmapped codes give 0.
module scancode_to_ascii (
    input  logic [7:0] scancode,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [15:0] pair;  // {unshifted, shifted}

    // Lookup of both characters for a key, then select by shift
    always_comb begin
        pair = 16'h0000;
        case (scancode)
            8'h1C: pair = {8'h61, 8'h41}; 8'h32: pair = {8'h62, 8'h42};
            8'h21: pair = {8'h63, 8'h43}; 8'h23: pair = {8'h64, 8'h44};
            8'h24: pair = {8'h65, 8'h45}; 8'h2B: pair = {8'h66, 8'h46};
            8'h34: pair = {8'h67, 8'h47}; 8'h33: pair = {8'h68, 8'h48};
            8'h43: pair = {8'h69, 8'h49}; 8'h3B: pair = {8'h6A, 8'h4A};
            8'h42: pair = {8'h6B, 8'h4B}; 8'h4B: pair = {8'h6C, 8'h4C};
            8'h3A: pair = {8'h6D, 8'h4D}; 8'h31: pair = {8'h6E, 8'h4E};
            8'h44: pair = {8'h6F, 8'h4F}; 8'h4D: pair = {8'h70, 8'h50};
            8'h15: pair = {8'h71, 8'h51}; 8'h2D: pair = {8'h72, 8'h52};
            8'h1B: pair = {8'h73, 8'h53}; 8'h2C: pair = {8'h74, 8'h54};
            8'h3C: pair = {8'h75, 8'h55}; 8'h2A: pair = {8'h76, 8'h56};
            8'h1D: pair = {8'h77, 8'h57}; 8'h22: pair = {8'h78, 8'h58};
            8'h35: pair = {8'h79, 8'h59}; 8'h1A: pair = {8'h7A, 8'h5A};
            8'h45: pair = {8'h30, 8'h29}; 8'h16: pair = {8'h31, 8'h21};
            8'h1E: pair = {8'h32, 8'h40}; 8'h26: pair = {8'h33, 8'h23};
            8'h25: pair = {8'h34, 8'h24}; 8'h2E: pair = {8'h35, 8'h25};
            8'h36: pair = {8'h36, 8'h5E}; 8'h3D: pair = {8'h37, 8'h26};
            8'h3E: pair = {8'h38, 8'h2A}; 8'h46: pair = {8'h39, 8'h28};
            8'h29: pair = {8'h20, 8'h20}; 8'h5A: pair = {8'h0A, 8'h0A};
            8'h66: pair = {8'h08, 8'h08}; 8'h4E: pair = {8'h2D, 8'h5F};
            8'h55: pair = {8'h3D, 8'h2B}; 8'h54: pair = {8'h5B, 8'h7B};
            8'h5B: pair = {8'h5D, 8'h7D}; 8'h4C: pair = {8'h3B, 8'h3A};
            8'h52: pair = {8'h27, 8'h22}; 8'h41: pair = {8'h2C, 8'h3C};
            8'h49: pair = {8'h2E, 8'h3E}; 8'h4A: pair = {8'h2F, 8'h3F};
            default: pair = 16'h0000;
        endcase
        ascii = shift ? pair[7:0] : pair[15:8];
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver, set-2 decoder and FWFT character FIFO feeding the
// keyboard MMIO word. Define KB_SHIFT_EN to track left/right shift.
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       key_rd,
    output logic [7:0] input_ascii,
    output logic       input_en,
    output logic       overflow,
    output logic       frame_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]    clk_sync, dat_sync;
    logic          fall_c, bit_in_c;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [10:0]   frame_bits;
    logic          frame_done, frame_ok_c;
    logic [TW-1:0] idle_cnt;
    logic          rx_strobe;
    logic [7:0]    rx_byte;

    // Three-flop synchronisers on the raw PS/2 lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= 3'b111;
            dat_sync <= 3'b111;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[1:0], ps2_data};
        end
    end

    assign fall_c     = clk_sync[2] & ~clk_sync[1];
    assign bit_in_c   = dat_sync[1];
    // frame_bits: [0] start, [8:1] data, [9] parity, [10] stop
    assign frame_ok_c = ~frame_bits[0] & frame_bits[10] & (^frame_bits[9:1]);

    // Bit counter, shift register, idle timeout and frame check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= 4'd0;
            shreg      <= 10'd0;
            frame_bits <= 11'd0;
            frame_done <= 1'b0;
            idle_cnt   <= '0;
            rx_strobe  <= 1'b0;
            rx_byte    <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            rx_strobe  <= 1'b0;
            frame_err  <= 1'b0;
            if (fall_c) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'(FRAME_LAST_BIT)) begin
                    frame_bits <= {bit_in_c, shreg};
                    frame_done <= 1'b1;
                    bit_cnt    <= 4'd0;
                end else begin
                    shreg   <= {bit_in_c, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt  <= 4'd0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
            if (frame_done) begin
                if (frame_ok_c) begin
                    rx_strobe <= 1'b1;
                    rx_byte   <= frame_bits[8:1];
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    kb_state_e  state_q, state_n;
    logic       push_c;
    logic [7:0] ascii_c;
    logic       shift_q;
`ifdef KB_SHIFT_EN
    logic       shift_n;
    logic       is_shift_c;
    assign is_shift_c = (rx_byte == KB_LSHIFT) || (rx_byte == KB_RSHIFT);
`else
    assign shift_q = 1'b0;
`endif

    scancode_to_ascii u_xlat (
        .scancode (rx_byte),
        .shift    (shift_q),
        .ascii    (ascii_c)
    );

    // Decoder state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_NORM;
`ifdef KB_SHIFT_EN
            shift_q <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
`ifdef KB_SHIFT_EN
            shift_q <= shift_n;
`endif
        end
    end

    // Decoder next state: prefixes, releases and make-code pushes
    always_comb begin
        state_n = state_q;
        push_c  = 1'b0;
`ifdef KB_SHIFT_EN
        shift_n = shift_q;
`endif
        if (rx_strobe) begin
            case (state_q)
                S_NORM: begin
                    if (rx_byte == KB_BRK) begin
                        state_n = S_BRK;
                    end else if (rx_byte == KB_EXT) begin
                        state_n = S_EXT;
`ifdef KB_SHIFT_EN
                    end else if (is_shift_c) begin
                        shift_n = 1'b1;
`endif
                    end else begin
                        push_c = (ascii_c != 8'h00);
                    end
                end
                S_BRK: begin
                    state_n = S_NORM;
`ifdef KB_SHIFT_EN
                    if (is_shift_c) shift_n = 1'b0;
`endif
                end
                S_EXT:    state_n = (rx_byte == KB_BRK) ? S_EXTBRK : S_NORM;
                S_EXTBRK: state_n = S_NORM;
                default:  state_n = S_NORM;
            endcase
        end
    end

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_n_c;
    logic [CW-1:0] count, count_n_c;
    logic          key_rd_q, pop_c, push_ok_c;
    logic [7:0]    head_n_c;

    assign pop_c     = key_rd & ~key_rd_q & (count != '0);
    assign push_ok_c = push_c & ((count != CW'(DEPTH)) | pop_c);
    assign count_n_c = count + CW'(push_ok_c) - CW'(pop_c);
    assign rd_n_c    = rd_ptr + PW'(pop_c);
    // A write landing on the new head slot is not in mem yet, so bypass it
    assign head_n_c  = (count_n_c == '0) ? 8'h00 :
                       (push_ok_c && (rd_n_c == wr_ptr)) ? ascii_c : mem[rd_n_c];

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr] <= ascii_c;
    end

    // FIFO pointers, count, sticky overflow and registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            key_rd_q    <= 1'b0;
            overflow    <= 1'b0;
            input_ascii <= 8'h00;
            input_en    <= 1'b0;
        end else begin
            key_rd_q    <= key_rd;
            wr_ptr      <= wr_ptr + PW'(push_ok_c);
            rd_ptr      <= rd_n_c;
            count       <= count_n_c;
            overflow    <= overflow | (push_c & ~push_ok_c);
            input_ascii <= head_n_c;
            input_en    <= (count_n_c != '0);
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: frames, prefixes, errors, timeout, FIFO.
module tb_ps2_keyboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_rd = 1'b0;
    logic [7:0] input_ascii;
    logic       input_en, overflow, frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int err_base;

    ps2_keyboard #(.DEPTH(8), .TIMEOUT_CYC(200)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_rd      (key_rd),
        .input_ascii (input_ascii),
        .input_en    (input_en),
        .overflow    (overflow),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err) err_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        ps2_data = v;
        repeat (5) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic pop(input int hold);
        @(negedge clk) key_rd = 1'b1;
        repeat (hold) @(negedge clk);
        key_rd = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] digits [8];
    logic [7:0] up_a;

    initial begin
        digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
`ifdef KB_SHIFT_EN
        up_a = 8'h41;
`else
        up_a = 8'h61;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_en", 32'(input_en), 32'd0);
        check_eq("rst_ascii", 32'(input_ascii), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single make 1C
        send_frame(8'h1C, 1'b0);
        @(negedge clk);
        check_eq("a_en", 32'(input_en), 32'd1);
        check_eq("a_ascii", 32'(input_ascii), 32'h61);
        pop(1);
        check_eq("a_pop_en", 32'(input_en), 32'd0);
        check_eq("a_pop_ascii", 32'(input_ascii), 32'h00);

        // Make then release queues one char
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        @(negedge clk);
        check_eq("brk_ascii", 32'(input_ascii), 32'h61);
        pop(1);
        check_eq("brk_empty", 32'(input_en), 32'd0);

        // Extended up-arrow make/break queues nothing
        err_base = err_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        @(negedge clk);
        check_eq("ext_en", 32'(input_en), 32'd0);
        check_eq("ext_ferr", 32'(err_cnt - err_base), 32'd0);

        // Bad parity
        err_base = err_cnt;
        send_frame(8'h1C, 1'b1);
        @(negedge clk);
        check_eq("par_ferr", 32'(err_cnt - err_base), 32'd1);
        check_eq("par_en", 32'(input_en), 32'd0);

        // Partial frame abandoned by idle timeout
        err_base = err_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        ps2_data = 1'b1;
        repeat (300) @(posedge clk);
        send_frame(8'h32, 1'b0);
        @(negedge clk);
        check_eq("to_ascii", 32'(input_ascii), 32'h62);
        check_eq("to_ferr", 32'(err_cnt - err_base), 32'd0);
        pop(1);
        check_eq("to_empty", 32'(input_en), 32'd0);

        // Overflow: ten makes into an eight-deep FIFO
        send_frame(8'h16, 1'b0); send_frame(8'h1E, 1'b0);
        send_frame(8'h26, 1'b0); send_frame(8'h25, 1'b0);
        send_frame(8'h2E, 1'b0); send_frame(8'h36, 1'b0);
        send_frame(8'h3D, 1'b0); send_frame(8'h3E, 1'b0);
        check_eq("ovf_pre", 32'(overflow), 32'd0);
        send_frame(8'h46, 1'b0); send_frame(8'h45, 1'b0);
        @(negedge clk);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        check_eq("ovf_head", 32'(input_ascii), 32'(digits[0]));
        pop(3);
        check_eq("hold_one_pop", 32'(input_ascii), 32'(digits[1]));
        for (int i = 2; i < 8; i++) begin
            pop(1);
            check_eq($sformatf("ovf_rd%0d", i), 32'(input_ascii), 32'(digits[i]));
        end
        pop(1);
        check_eq("ovf_drain", 32'(input_en), 32'd0);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);

        // Shift held over one letter
        send_frame(8'h12, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h12, 1'b0);
        send_frame(8'h1C, 1'b0);
        @(negedge clk);
        check_eq("sh_first", 32'(input_ascii), 32'(up_a));
        pop(1);
        check_eq("sh_second", 32'(input_ascii), 32'h61);
        pop(1);
        check_eq("sh_empty", 32'(input_en), 32'd0);

        // Reset clears sticky overflow
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check_eq("rst2_ovf", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
